// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : round-robin arbiter/sequencer for the shared data memory
// Revision 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [2:0]        ctrl0_i,
    input  logic [2:0]        ctrl1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [2:0]        mem_ctrl_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               w_grant;
    logic               w_sel;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        w_grant   = 1'b0;
        w_sel     = 1'b0;
        gnt0_o    = 1'b0;
        gnt1_o    = 1'b0;
        rvalid0_o = 1'b0;
        rvalid1_o = 1'b0;
        mem_en_o  = 1'b0;
        mem_we_o  = 1'b0;

        // Outputs are suppressed while rst is high so a pending read is dropped.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req0_i && (!req1_i || last_q)) begin
                        w_grant = 1'b1;
                        w_sel   = 1'b0;
                    end else if (req1_i) begin
                        w_grant = 1'b1;
                        w_sel   = 1'b1;
                    end
                end
                RD_WAIT: begin
                    rvalid0_o = ~owner_q;
                    rvalid1_o = owner_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (w_grant) begin
            gnt0_o   = ~w_sel;
            gnt1_o   = w_sel;
            mem_en_o = 1'b1;
            mem_we_o = w_sel ? we1_i : we0_i;
            last_d   = w_sel;
            if (!mem_we_o) begin
                state_d = RD_WAIT;
                owner_d = w_sel;
            end
        end

        mem_addr_o  = w_sel ? addr1_i  : addr0_i;
        mem_wdata_o = w_sel ? wdata1_i : wdata0_i;
        mem_ctrl_o  = w_sel ? ctrl1_i  : ctrl0_i;
    end

    assign rdata_o     = mem_rdata_i;
    assign cpu_stall_o = req0_i & ~(gnt0_o & we0_i) & ~rvalid0_o;
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed + randomized bench with a behavioural model
// Revision 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  ctrl0, ctrl1;
    logic        gnt0, gnt1, rvalid0, rvalid1, cpu_stall, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_ctrl;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ctrl0_i(ctrl0), .ctrl1_i(ctrl1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata_o(rdata), .cpu_stall_o(cpu_stall),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ctrl_o(mem_ctrl), .mem_rdata_i(mem_rdata),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory driven by the DUT's memory-side outputs
    logic [31:0] dmem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= dmem[mem_addr[5:2]];
        end
    end

    // Behavioural model: who wins, what is pending, what memory holds
    logic [31:0] mmem [16];
    int          m_pend = -1;
    int          m_last = 1;
    int          m_cnt  = 0;
    logic [31:0] m_pdata;
    int          win;
    bit          e_rv0, e_rv1, e_we, e_st;
    logic [31:0] w_addr, w_wd;
    logic [2:0]  w_ctrl;

    always @(negedge clk) begin
        if (run) begin
            win   = -1;
            e_rv0 = 1'b0;
            e_rv1 = 1'b0;
            if (!rst) begin
                if (m_pend >= 0) begin
                    e_rv0 = (m_pend == 0);
                    e_rv1 = (m_pend == 1);
                end else if (req0 && req1) win = (m_last == 1) ? 0 : 1;
                else if (req0) win = 0;
                else if (req1) win = 1;
            end
            e_we   = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
            w_addr = (win == 1) ? addr1  : addr0;
            w_wd   = (win == 1) ? wdata1 : wdata0;
            w_ctrl = (win == 1) ? ctrl1  : ctrl0;
            e_st   = req0 && !((win == 0) && we0) && !e_rv0;

            chk("gnt0", 32'(gnt0), 32'(win == 0));
            chk("gnt1", 32'(gnt1), 32'(win == 1));
            chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
            chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
            chk("mem_en", 32'(mem_en), 32'(win >= 0));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
            if (win >= 0) begin
                chk("mem_addr", mem_addr, w_addr);
                chk("mem_wdata", mem_wdata, w_wd);
                chk("mem_ctrl", 32'(mem_ctrl), 32'(w_ctrl));
            end
            if (e_rv0 || e_rv1) chk("rdata", rdata, m_pdata);
            if (!rst) chk("cpu_stall", 32'(cpu_stall), 32'(e_st));

            if (rst) begin
                m_pend = -1;
                m_last = 1;
                m_cnt  = 0;
            end else begin
                if (m_pend >= 0) m_pend = -1;
                else if (win >= 0) begin
                    m_last = win;
                    if (e_we) mmem[w_addr[5:2]] = w_wd;
                    else begin
                        m_pend  = win;
                        m_pdata = mmem[w_addr[5:2]];
                    end
                end
                if (e_st && m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Randomized requester that obeys the hold-until-gnt/rvalid rules
    task automatic rand_phase(input int cycles);
        bit g0, g1, v0, v1;
        for (int c = 0; c < cycles; c++) begin
            smp();
            g0 = gnt0; g1 = gnt1; v0 = rvalid0; v1 = rvalid1;
            nxt();
            if (req0 && ((g0 && we0) || v0)) req0 = 1'b0;
            else if (req0 && !g0 && $urandom_range(0, 19) == 0) req0 = 1'b0;
            if (req1 && ((g1 && we1) || v1)) req1 = 1'b0;
            else if (req1 && !g1 && $urandom_range(0, 19) == 0) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; we0 = 1'($urandom); addr0 = $urandom;
                wdata0 = $urandom; ctrl0 = 3'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; we1 = 1'($urandom); addr1 = $urandom;
                wdata1 = $urandom; ctrl1 = 3'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dmem[i] = $urandom;
            mmem[i] = dmem[i];
        end
        dmem[4] = 32'hDEADBEEF;
        mmem[4] = 32'hDEADBEEF;
        mem_rdata = '0;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = '0; ctrl0 = 3'b010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14; wdata1 = '0; ctrl1 = 3'b010;

        // Reset held with both ports requesting
        for (int k = 0; k < 2; k++) begin
            smp();
            chk("rst_gnt0", 32'(gnt0), 32'd0);
            chk("rst_gnt1", 32'(gnt1), 32'd0);
            chk("rst_en", 32'(mem_en), 32'd0);
            chk("rst_cnt", 32'(stall_cnt), 32'd0);
            nxt();
        end
        rst = 1'b0;

        // Back-to-back contending loads: grants 0,1,0,1
        for (int k = 0; k < 8; k++) begin
            if (k > 0) nxt();
            smp();
            chk("ct_gnt0", 32'(gnt0), 32'(k == 0 || k == 4));
            chk("ct_gnt1", 32'(gnt1), 32'(k == 2 || k == 6));
            chk("ct_rv0", 32'(rvalid0), 32'(k == 1 || k == 5));
            chk("ct_rv1", 32'(rvalid1), 32'(k == 3 || k == 7));
            if (k <= 6) chk("ct_stall", 32'(cpu_stall), 32'(k == 0 || k == 2 || k == 3 || k == 4 || k == 6));
            if (k == 1) chk("ct_rdata", rdata, 32'hDEADBEEF);
        end
        nxt(); req0 = 1'b0; req1 = 1'b0;
        smp(); chk("ct_cnt", 32'(stall_cnt), 32'd6);

        // CPU load alone
        nxt(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        smp(); chk("ld_gnt0", 32'(gnt0), 32'd1); chk("ld_stall0", 32'(cpu_stall), 32'd1);
        nxt();
        smp(); chk("ld_rv0", 32'(rvalid0), 32'd1); chk("ld_rdata", rdata, 32'hDEADBEEF);
        chk("ld_stall1", 32'(cpu_stall), 32'd0);
        nxt(); req0 = 1'b0;
        smp(); chk("ld_cnt", 32'(stall_cnt), 32'd7);

        // CPU store alone
        nxt(); req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678; ctrl0 = 3'b010;
        smp(); chk("st_gnt0", 32'(gnt0), 32'd1); chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h20); chk("st_ctrl", 32'(mem_ctrl), 32'd2);
        chk("st_stall", 32'(cpu_stall), 32'd0);
        nxt(); req0 = 1'b0;
        smp(); chk("st_norv", 32'(rvalid0), 32'd0); chk("st_cnt", 32'(stall_cnt), 32'd7);

        // Port 1 store arriving while the CPU load is in RD_WAIT
        nxt(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        smp(); chk("hd_gnt0", 32'(gnt0), 32'd1);
        nxt(); req1 = 1'b1; we1 = 1'b1; addr1 = 32'h24; wdata1 = 32'hCAFEF00D; ctrl1 = 3'b001;
        smp(); chk("hd_gnt1_off", 32'(gnt1), 32'd0); chk("hd_rv0", 32'(rvalid0), 32'd1);
        chk("hd_rdata", rdata, 32'h12345678);
        nxt();
        smp(); chk("hd_gnt1", 32'(gnt1), 32'd1); chk("hd_gnt0_off", 32'(gnt0), 32'd0);
        chk("hd_addr", mem_addr, 32'h24);
        nxt(); req1 = 1'b0;
        smp(); chk("hd_gnt0b", 32'(gnt0), 32'd1);
        nxt();
        nxt(); req0 = 1'b0;

        // Reset asserted in RD_WAIT
        nxt(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h24;
        smp(); chk("rr_gnt0", 32'(gnt0), 32'd1);
        nxt(); rst = 1'b1;
        smp(); chk("rr_drop", 32'(rvalid0), 32'd0);
        nxt(); rst = 1'b0;
        smp(); chk("rr_regnt", 32'(gnt0), 32'd1); chk("rr_cnt", 32'(stall_cnt), 32'd0);
        nxt();
        smp(); chk("rr_rdata", rdata, 32'hCAFEF00D);
        nxt(); req0 = 1'b0; req1 = 1'b0;

        rand_phase(3000);

        // Saturation: a held CPU load stream stalls every other cycle
        nxt(); rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        nxt(); rst = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        for (int k = 0; k < 700; k++) nxt();
        smp(); chk("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        nxt(); req0 = 1'b0;
        smp();
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
